// File: rtl/pc_sequencer_pkg.sv
// Shared processor definitions: branch condition codes, flag bit positions
// and the sequencer state encoding.
package pc_sequencer_pkg;

   localparam logic [2:0] COND_NE = 3'b000;  // Z==0
   localparam logic [2:0] COND_EQ = 3'b001;  // Z==1
   localparam logic [2:0] COND_GT = 3'b010;  // Z==0 & N==0
   localparam logic [2:0] COND_LT = 3'b011;  // N==1
   localparam logic [2:0] COND_GE = 3'b100;  // Z==1 | (Z==0 & N==0)
   localparam logic [2:0] COND_LE = 3'b101;  // N==1 | Z==1
   localparam logic [2:0] COND_VS = 3'b110;  // V==1
   localparam logic [2:0] COND_AL = 3'b111;  // always

   // flags vector layout is {N,Z,V}
   localparam int FLAG_N = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_V = 0;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } seq_state_t;

endpackage

// File: rtl/pc_sequencer_cond_eval.sv
// Evaluates a 3-bit branch condition code against the {N,Z,V} flags.
// Latency: purely combinational.
// Backpressure: none.
module cond_eval
   import pc_sequencer_pkg::*;
(
   input  logic [2:0] cond,
   input  logic [2:0] flags,
   output logic       cond_true
);

   logic n, z, v;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign v = flags[FLAG_V];

   always_comb begin
      cond_true = 1'b1;
      case (cond)
         COND_NE: cond_true = !z;
         COND_EQ: cond_true = z;
         COND_GT: cond_true = !z && !n;
         COND_LT: cond_true = n;
         COND_GE: cond_true = z || (!z && !n);
         COND_LE: cond_true = n || z;
         COND_VS: cond_true = v;
         default: cond_true = 1'b1;
      endcase
   end

endmodule

// File: rtl/pc_sequencer_dff.sv
// Single-bit storage cell with write enable and a per-instance reset value.
// Latency: q follows d one clk edge after en; reset is immediate.
// Backpressure: none; en=0 simply holds the bit.
module pc_sequencer_dff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic d,
   output logic q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= RST_VAL;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: sequential fetch, B/BR branches, flags, HLT.
// Latency: pc/flags/halted update one clk edge after the deciding inputs.
// Backpressure: stall freezes pc, flags and state for that cycle.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              halt_req,
   input  logic              br_imm,
   input  logic              br_reg,
   input  logic [2:0]        cond,
   input  logic [8:0]        offset,
   input  logic [ADDR_W-1:0] reg_target,
   input  logic [2:0]        flag_wen,
   input  logic [2:0]        flag_in,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus2,
   output logic              taken,
   output logic              halted,
   output logic [2:0]        flags
);

   seq_state_t        state_q, state_d;
   logic              run;
   logic              advance;
   logic              cond_true;
   logic [ADDR_W-1:0] off_ext;
   logic [ADDR_W-1:0] br_target;
   logic [ADDR_W-1:0] pc_d;
   logic              pc_en;
   logic [2:0]        flag_en;

   cond_eval u_cond_eval (
      .cond      (cond),
      .flags     (flags),
      .cond_true (cond_true)
   );

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= ST_RUN;
      else
         state_q <= state_d;
   end

   // next state: only an unstalled HLT leaves RUN; only rst leaves HALT
   always_comb begin
      state_d = state_q;
      if (state_q == ST_RUN && !stall && halt_req)
         state_d = ST_HALT;
   end

   // state-decoded outputs
   always_comb begin
      run    = (state_q == ST_RUN);
      halted = (state_q == ST_HALT);
   end

   assign advance  = run && !stall;
   assign taken    = (br_imm || br_reg) && cond_true && advance && !halt_req;
   assign pc_plus2 = pc + ADDR_W'(2);

   // br_reg wins when both branch kinds are decoded together
   assign off_ext   = {{(ADDR_W-9){offset[8]}}, offset};
   assign br_target = br_reg ? (reg_target & ~ADDR_W'(1))
                             : pc_plus2 + {off_ext[ADDR_W-2:0], 1'b0};

   assign pc_d    = taken ? br_target : pc_plus2;
   assign pc_en   = advance && !halt_req;
   assign flag_en = flag_wen & {3{advance}};

   for (genvar i = 0; i < ADDR_W; i++) begin : g_pc
      pc_sequencer_dff #(.RST_VAL(RESET_PC[i])) u_bit (
         .clk (clk),
         .rst (rst),
         .en  (pc_en),
         .d   (pc_d[i]),
         .q   (pc[i])
      );
   end

   for (genvar i = 0; i < 3; i++) begin : g_flag
      pc_sequencer_dff #(.RST_VAL(1'b0)) u_bit (
         .clk (clk),
         .rst (rst),
         .en  (flag_en[i]),
         .d   (flag_in[i]),
         .q   (flags[i])
      );
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios then random traffic,
// checked against a cycle-level behavioural model.
module tb_pc_sequencer;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        halt_req;
   logic        br_imm;
   logic        br_reg;
   logic [2:0]  cond;
   logic [8:0]  offset;
   logic [15:0] reg_target;
   logic [2:0]  flag_wen;
   logic [2:0]  flag_in;
   logic [15:0] pc;
   logic [15:0] pc_plus2;
   logic        taken;
   logic        halted;
   logic [2:0]  flags;

   pc_sequencer #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .halt_req   (halt_req),
      .br_imm     (br_imm),
      .br_reg     (br_reg),
      .cond       (cond),
      .offset     (offset),
      .reg_target (reg_target),
      .flag_wen   (flag_wen),
      .flag_in    (flag_in),
      .pc         (pc),
      .pc_plus2   (pc_plus2),
      .taken      (taken),
      .halted     (halted),
      .flags      (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int   pre_pc;
      int   pre_flags;
      bit   pre_halted;
      bit   exp_taken;
      int   exp_pp2;
      int   post_pc;
      int   post_flags;
      bit   post_halted;
   } rec_t;

   rec_t q[$];
   int   errors = 0;
   int   checks = 0;

   // behavioural model state
   int m_pc     = 0;
   int m_flags  = 0;
   bit m_halted = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit cond_ok(input int c, input int f);
      bit n, z, v;
      n = f[2]; z = f[1]; v = f[0];
      case (c)
         0: return !z;
         1: return z;
         2: return !z && !n;
         3: return n;
         4: return z || (!z && !n);
         5: return n || z;
         6: return v;
         default: return 1'b1;
      endcase
   endfunction

   task automatic drive(input bit r, input bit s, input bit h, input bit bi, input bit brr,
                        input logic [2:0] c, input logic [8:0] o, input logic [15:0] rt,
                        input logic [2:0] fw, input logic [2:0] fi);
      rec_t rec;
      int   so;
      @(negedge clk);
      rst = r; stall = s; halt_req = h; br_imm = bi; br_reg = brr;
      cond = c; offset = o; reg_target = rt; flag_wen = fw; flag_in = fi;
      if (r) begin
         m_pc = 0; m_flags = 0; m_halted = 1'b0;
      end
      rec.pre_pc     = m_pc;
      rec.pre_flags  = m_flags;
      rec.pre_halted = m_halted;
      rec.exp_pp2    = (m_pc + 2) & 16'hFFFF;
      rec.exp_taken  = (bi || brr) && cond_ok(int'(c), m_flags) && !m_halted && !s && !h;
      if (!r && !m_halted && !s) begin
         if (h)
            m_halted = 1'b1;
         else if (rec.exp_taken) begin
            so = o[8] ? int'(o) - 512 : int'(o);
            m_pc = brr ? (int'(rt) & 16'hFFFE) : ((rec.exp_pp2 + 2 * so) & 16'hFFFF);
         end else
            m_pc = rec.exp_pp2;
         for (int i = 0; i < 3; i++)
            if (fw[i]) m_flags[i] = fi[i];
      end
      rec.post_pc     = m_pc;
      rec.post_flags  = m_flags;
      rec.post_halted = m_halted;
      q.push_back(rec);
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 3'b000, 9'h000, 16'h0000, 3'b000, 3'b000);
   endtask

   task automatic jump(input logic [15:0] a);
      drive(0, 0, 0, 0, 1, 3'b111, 9'h000, a, 3'b000, 3'b000);
   endtask

   task automatic do_reset();
      drive(1, 0, 0, 0, 0, 3'b000, 9'h000, 16'h0000, 3'b000, 3'b000);
   endtask

   // monitor: combinational outputs mid-cycle, registered outputs after the edge
   initial begin
      rec_t r;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() != 0) begin
            r = q.pop_front();
            chk("pc", int'(pc), r.pre_pc);
            chk("flags", int'(flags), r.pre_flags);
            chk("halted", int'(halted), int'(r.pre_halted));
            chk("pc_plus2", int'(pc_plus2), r.exp_pp2);
            chk("taken", int'(taken), int'(r.exp_taken));
            @(posedge clk);
            #1;
            chk("next_pc", int'(pc), r.post_pc);
            chk("next_flags", int'(flags), r.post_flags);
            chk("next_halted", int'(halted), int'(r.post_halted));
         end
      end
   end

   initial begin
      rst = 1'b1; stall = 1'b0; halt_req = 1'b0; br_imm = 1'b0; br_reg = 1'b0;
      cond = '0; offset = '0; reg_target = '0; flag_wen = '0; flag_in = '0;

      // reset then sequential fetch
      do_reset();
      repeat (4) idle();

      // B with Z=1: cond EQ taken backwards, cond NE falls through
      drive(0, 0, 0, 0, 1, 3'b111, 9'h000, 16'h0010, 3'b010, 3'b010);
      drive(0, 0, 0, 1, 0, 3'b001, 9'h1FC, 16'h0000, 3'b000, 3'b000);
      jump(16'h0010);
      drive(0, 0, 0, 1, 0, 3'b000, 9'h1FC, 16'h0000, 3'b000, 3'b000);

      // flag write and branch together: branch sees old Z=0
      drive(0, 0, 0, 0, 0, 3'b000, 9'h000, 16'h0000, 3'b010, 3'b000);
      drive(0, 0, 0, 1, 0, 3'b001, 9'h010, 16'h0000, 3'b010, 3'b010);
      idle();

      // halt has priority over branch; HALT ignores everything until reset
      jump(16'h0020);
      drive(0, 0, 1, 0, 1, 3'b111, 9'h000, 16'h1000, 3'b000, 3'b000);
      repeat (5)
         drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 1, 3'b111,
               9'($urandom), 16'($urandom), 3'b111, 3'($urandom));
      do_reset();
      idle();

      // wrap-around and BR bit-0 masking
      jump(16'hFFFE);
      idle();
      drive(0, 0, 0, 0, 1, 3'b111, 9'h000, 16'h1235, 3'b000, 3'b000);
      drive(0, 0, 0, 1, 0, 3'b111, 9'h0FF, 16'h0000, 3'b000, 3'b000);
      jump(16'hFFF0);
      drive(0, 0, 0, 1, 0, 3'b111, 9'h010, 16'h0000, 3'b000, 3'b000);

      // stall holds pc/state even with halt_req pulsed
      jump(16'h0040);
      drive(0, 1, 0, 0, 0, 3'b000, 9'h000, 16'h0000, 3'b111, 3'b111);
      drive(0, 1, 1, 1, 1, 3'b111, 9'h000, 16'h0000, 3'b111, 3'b111);
      drive(0, 1, 0, 0, 0, 3'b000, 9'h000, 16'h0000, 3'b000, 3'b000);
      idle();

      // random traffic, halts kept rare so RUN dominates
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 59) == 0,
               $urandom_range(0, 4) == 0,
               $urandom_range(0, 39) == 0,
               1'($urandom), 1'($urandom_range(0, 3) == 0),
               3'($urandom), 9'($urandom), 16'($urandom),
               3'($urandom), 3'($urandom));
      end

      // mid-HALT reset
      idle();
      drive(0, 0, 1, 0, 0, 3'b000, 9'h000, 16'h0000, 3'b000, 3'b000);
      idle();
      do_reset();
      idle();

      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d records left, expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // guard against a stuck run
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
